// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side controller for sync_fifo. Pops words from the FIFO read port and
// presents them on a valid/ready stream. A 2-entry output buffer absorbs the
// FIFO's one-cycle read latency, so the stream sustains one beat per cycle.
// The last beat of every BURST_LEN-beat burst is tagged with m_last.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                allows new FIFO reads to be issued
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        FIFO read strobe (combinational)
//   fifo_rd_data      FIFO read data, valid the cycle after fifo_rd_en
//   m_valid/m_ready   output stream handshake
//   m_data, m_last    output beat data and end-of-burst tag
//   rd_count          number of FIFO pops since reset (wraps)
//   busy              a read is in flight or the buffer holds data
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [7:0]            beat_idx_q, beat_idx_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [DATA_WIDTH-1:0] buf_data_d [2];
  logic                  buf_last_q [2];
  logic                  buf_last_d [2];

  logic                  pop;
  logic [2:0]            level_after_pop;

  always_comb begin
    // Outputs are forced to zero while reset is asserted, not only after it.
    m_valid  = !rst && (occ_q != 2'd0);
    m_data   = m_valid ? buf_data_q[head_q] : '0;
    m_last   = m_valid && buf_last_q[head_q];
    busy     = !rst && (inflight_q || (occ_q != 2'd0));
    rd_count = rd_count_q;

    pop = m_valid && m_ready;

    // Occupancy the buffer will have once the in-flight word lands and the
    // current beat (if any) leaves; a new read is only issued if it fits.
    level_after_pop = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en      = en && !fifo_empty && !rst && (level_after_pop < 3'd2);

    occ_d      = level_after_pop[1:0];
    inflight_d = fifo_rd_en;
    head_d     = head_q;
    tail_d     = tail_q;
    beat_idx_d = beat_idx_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    rd_count_d = rd_count_q + CNT_WIDTH'(fifo_rd_en);

    if (inflight_q) begin
      buf_data_d[tail_q] = fifo_rd_data;
      buf_last_d[tail_q] = (beat_idx_q == LAST_IDX);
      tail_d             = ~tail_q;
      beat_idx_d         = (beat_idx_q == LAST_IDX) ? 8'd0 : beat_idx_q + 8'd1;
    end

    if (pop) begin
      head_d = ~head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      beat_idx_q <= 8'd0;
      rd_count_q <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_idx_q <= beat_idx_d;
      rd_count_q <= rd_count_d;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= buf_data_d[i];
        buf_last_q[i] <= buf_last_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. Two instances (BURST_LEN 4 and 1) see the
// same stimulus, each fed by its own behavioural sync_fifo model. Pushed words
// go into a per-instance expected queue tagged with their burst position; a
// negedge monitor pops and compares every accepted beat and checks the
// buffer-capacity, busy, rd_count and stall-hold rules.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int BL [2] = '{4, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, en, m_ready;
  logic [1:0]           fifo_empty;
  logic [1:0]           fifo_rd_en;
  logic [1:0][DW-1:0]   rd_data;
  logic [1:0]           m_valid;
  logic [1:0][DW-1:0]   m_data;
  logic [1:0]           m_last;
  logic [1:0][15:0]     rd_count;
  logic [1:0]           busy;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(4), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty[0]),
    .fifo_rd_en(fifo_rd_en[0]), .fifo_rd_data(rd_data[0]),
    .m_valid(m_valid[0]), .m_data(m_data[0]), .m_last(m_last[0]),
    .m_ready(m_ready), .rd_count(rd_count[0]), .busy(busy[0]));

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty[1]),
    .fifo_rd_en(fifo_rd_en[1]), .fifo_rd_data(rd_data[1]),
    .m_valid(m_valid[1]), .m_data(m_data[1]), .m_last(m_last[1]),
    .m_ready(m_ready), .rd_count(rd_count[1]), .busy(busy[1]));

  logic [DW-1:0] fq   [2][$];
  logic [DW:0]   expq [2][$];
  int pops [2];
  int acc  [2];
  int widx [2];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cyc[$];
  int beat_cyc[$];
  logic        stall_prev [2];
  logic [DW:0] stall_val  [2];

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, k, act, exp, $time);
    end
  endfunction

  // sync_fifo model: empty updates on the same edge that consumes a word.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (fifo_rd_en[k]) begin
        chk("rd_while_empty", k, 32'(fq[k].size() != 0), 32'd1);
        if (fq[k].size() != 0) rd_data[k] <= fq[k].pop_front();
        pops[k]++;
        if (k == 0) rd_cyc.push_back(cyc);
      end
      fifo_empty[k] <= (fq[k].size() == 0);
    end
    cyc++;
  end

  always @(negedge clk) begin
    int o;
    logic [DW:0] e;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("reset_outputs", k,
            {20'd0, fifo_rd_en[k], m_valid[k], m_last[k], busy[k], m_data[k]}, 32'd0);
        stall_prev[k] = 1'b0;
      end else begin
        o = pops[k] - acc[k];
        chk("buffer_capacity", k, 32'(o <= 2), 32'd1);
        chk("busy", k, 32'(busy[k]), 32'(o != 0));
        chk("rd_count", k, 32'(rd_count[k]), 32'(pops[k][15:0]));
        if (stall_prev[k])
          chk("stall_hold", k, {22'd0, m_valid[k], m_last[k], m_data[k]},
              {22'd0, 1'b1, stall_val[k]});
        if (m_valid[k] && m_ready) begin
          if (expq[k].size() == 0) begin
            chk("unexpected_beat", k, {23'd0, m_last[k], m_data[k]}, 32'hFFFF_FFFF);
          end else begin
            e = expq[k].pop_front();
            chk("beat_last_data", k, {23'd0, m_last[k], m_data[k]}, {23'd0, e});
          end
          acc[k]++;
          if (k == 0) beat_cyc.push_back(cyc);
        end
        stall_prev[k] = m_valid[k] && !m_ready;
        stall_val[k]  = {m_last[k], m_data[k]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fq[k].delete();
      expq[k].delete();
      pops[k] = 0;
      acc[k]  = 0;
      widx[k] = 0;
      fifo_empty[k] = 1'b1;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic push_word(logic [DW-1:0] w);
    logic last;
    for (int k = 0; k < 2; k++) begin
      last = ((widx[k] % BL[k]) == BL[k] - 1);
      expq[k].push_back({last, w});
      fq[k].push_back(w);
      widx[k]++;
      fifo_empty[k] = 1'b0;
    end
  endtask

  function automatic bit drained();
    return expq[0].size() == 0 && expq[1].size() == 0 &&
           fq[0].size() == 0 && fq[1].size() == 0 && busy == 2'b00;
  endfunction

  task automatic wait_drain(int budget);
    int i;
    for (i = 0; i < budget && !drained(); i++) tick();
    chk("drain_timeout", 0, 32'(drained()), 32'd1);
  endtask

  function automatic int gaps();
    int g = 0;
    for (int i = 0; i + 1 < beat_cyc.size(); i++)
      if (beat_cyc[i+1] - beat_cyc[i] != 1) g++;
    return g;
  endfunction

  initial begin
    int p;
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 2'b11;
    for (int k = 0; k < 2; k++) begin
      pops[k] = 0; acc[k] = 0; widx[k] = 0;
      stall_prev[k] = 1'b0; stall_val[k] = '0;
    end
    rd_data = '0;
    tick();

    // 1: stream 10 words at full rate
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(8'(i));
    rd_cyc.delete(); beat_cyc.delete();
    en = 1'b1;
    wait_drain(60);
    chk("t1_beats", 0, 32'(beat_cyc.size()), 32'd10);
    if (beat_cyc.size() > 0 && rd_cyc.size() > 0)
      chk("t1_first_latency", 0, 32'(beat_cyc[0] - rd_cyc[0]), 32'd2);
    chk("t1_gaps", 0, 32'(gaps()), 32'd0);
    chk("t1_rd_count", 0, 32'(rd_count[0]), 32'd10);

    // 2: backpressure
    do_reset();
    en = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'(i));
    en = 1'b1;
    repeat (5) tick();
    chk("t2_reads_held", 0, 32'(pops[0]), 32'd2);
    chk("t2_head_held", 0, {23'd0, m_valid[0], m_data[0]}, {23'd0, 1'b1, 8'd0});
    beat_cyc.delete();
    m_ready = 1'b1;
    wait_drain(60);
    chk("t2_beats", 0, 32'(beat_cyc.size()), 32'd10);
    chk("t2_gaps", 0, 32'(gaps()), 32'd0);

    // 3: en dropped for 3 cycles right after a read
    do_reset();
    en = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(8'(8'h20 + i));
    en = 1'b1;
    for (int i = 0; i < 20 && pops[0] < 3; i++) tick();
    en = 1'b0;
    p = pops[0];
    repeat (3) tick();
    chk("t3_no_reads_while_off", 0, 32'(pops[0]), 32'(p));
    en = 1'b1;
    wait_drain(60);
    chk("t3_all_delivered", 0, 32'(acc[0]), 32'd10);

    // 4: single word then empty FIFO
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    push_word(8'hA5);
    repeat (8) tick();
    chk("t4_pops", 0, 32'(pops[0]), 32'd1);
    chk("t4_rd_count", 0, 32'(rd_count[0]), 32'd1);
    chk("t4_beats", 0, 32'(acc[0]), 32'd1);
    chk("t4_rd_en_idle", 0, 32'(fifo_rd_en[0]), 32'd0);

    // 5: reset with a full buffer
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'(8'h40 + i));
    repeat (4) tick();
    chk("t5_full_before_reset", 0, 32'(pops[0]), 32'd2);
    do_reset();
    chk("t5_after_reset", 0,
        {13'd0, rd_count[0], m_valid[0], m_last[0], busy[0]}, 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'(8'h50 + i));
    wait_drain(40);
    chk("t5_beats", 0, 32'(acc[0]), 32'd4);

    // 6: alternating m_ready (dut1 has BURST_LEN 1)
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'(8'h60 + i));
    for (int i = 0; i < 80 && !drained(); i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    chk("t6_beats", 1, 32'(acc[1]), 32'd6);

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 4) < 2) push_word(8'($urandom));
      tick();
    end
    en = 1'b1; m_ready = 1'b1;
    wait_drain(400);
    chk("rand_all_delivered", 0, 32'(acc[0]), 32'(widx[0]));
    chk("rand_all_delivered", 1, 32'(acc[1]), 32'(widx[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
